// File: rtl/circle_run_ctrl_pkg.sv
// Shared types and constants for the circle run-counter controller.
// Build option: CIRCLE_RUN_DOWN_EN adds a latched count direction (down-count from RUN_MAX).
package circle_run_ctrl_pkg;

  typedef enum logic [1:0] {
    CR_IDLE = 2'd0,
    CR_RUN  = 2'd1,
    CR_STOP = 2'd2
  } cr_state_e;

  localparam logic CR_ONESHOT = 1'b0;
  localparam logic CR_LOOP    = 1'b1;

  // Start value of a run: zero when counting up, the terminal count when counting down.
  function automatic int unsigned cr_reload(input logic down, input int unsigned run_max);
    return down ? run_max : 0;
  endfunction

endpackage

// File: rtl/circle_run_ctrl_if.sv
// Control/status bundle between the sequencer (master) and circle_run_ctrl (slave).
// Build option: CIRCLE_RUN_DOWN_EN adds the run_dir request signal.
interface circle_run_ctrl_if #(
  parameter int PTN_W = 4,
  parameter int RUN_W = 3
);
  logic             start;
  logic             clr;
  logic             mode;
  logic [PTN_W-1:0] ptn_cnt;
`ifdef CIRCLE_RUN_DOWN_EN
  logic             run_dir;
`endif
  logic [RUN_W-1:0] run_cnt;
  logic             run_stop;
  logic             run_busy;
  logic             run_done;
  logic             run_wrap;

`ifdef CIRCLE_RUN_DOWN_EN
  modport master (output start, clr, mode, ptn_cnt, run_dir,
                  input  run_cnt, run_stop, run_busy, run_done, run_wrap);
  modport slave  (input  start, clr, mode, ptn_cnt, run_dir,
                  output run_cnt, run_stop, run_busy, run_done, run_wrap);
`else
  modport master (output start, clr, mode, ptn_cnt,
                  input  run_cnt, run_stop, run_busy, run_done, run_wrap);
  modport slave  (input  start, clr, mode, ptn_cnt,
                  output run_cnt, run_stop, run_busy, run_done, run_wrap);
`endif
endinterface

// File: rtl/circle_run_ctrl_ptn_wrap_det.sv
// Pass detector: one tick per arrival of the pattern counter at its last value,
// even if the counter stalls there.
module ptn_wrap_det #(
  parameter int PTN_W      = 4,
  parameter int CNT_LENGTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PTN_W-1:0] ptn_cnt,
  output logic             tick
);
  localparam logic [PTN_W-1:0] LAST_VAL = PTN_W'(CNT_LENGTH - 1);

  logic hit;
  logic last_q;

  assign hit = (ptn_cnt == LAST_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= hit;
    end
  end

  // A one-value period sits on the last value permanently, so every cycle is a pass.
  assign tick = hit && (!last_q || (CNT_LENGTH == 1));

endmodule

// File: rtl/circle_run_ctrl.sv
// IDLE/RUN/STOP controller counting completed pattern passes, one-shot or loop mode.
// Build option: CIRCLE_RUN_DOWN_EN enables down-counting selected by run_dir at start.
module circle_run_ctrl
  import circle_run_ctrl_pkg::*;
#(
  parameter int PTN_W      = 4,
  parameter int CNT_LENGTH = 8,
  parameter int RUN_W      = 3,
  parameter int RUN_MAX    = 7
) (
  input logic              clk,
  input logic              rst,
  circle_run_ctrl_if.slave ctrl_if
);
  localparam logic [RUN_W-1:0] RUN_TOP = RUN_W'(RUN_MAX);

  cr_state_e        state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             dir_in;
  logic             terminal;
  logic [RUN_W-1:0] reload_val;

`ifdef CIRCLE_RUN_DOWN_EN
  assign dir_in = ctrl_if.run_dir;
`else
  assign dir_in = 1'b0;
`endif

  ptn_wrap_det #(
    .PTN_W      (PTN_W),
    .CNT_LENGTH (CNT_LENGTH)
  ) u_det (
    .clk     (clk),
    .rst     (rst),
    .ptn_cnt (ctrl_if.ptn_cnt),
    .tick    (tick)
  );

  assign terminal   = dir_q ? (run_cnt_q == '0) : (run_cnt_q == RUN_TOP);
  assign reload_val = RUN_W'(cr_reload(dir_in, RUN_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CR_IDLE;
      run_cnt_q <= '0;
      mode_q    <= CR_ONESHOT;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    if (ctrl_if.clr) begin
      state_d   = CR_IDLE;
      run_cnt_d = '0;
    end else begin
      unique case (state_q)
        CR_IDLE: begin
          run_cnt_d = '0;
          if (ctrl_if.start) begin
            state_d   = CR_RUN;
            run_cnt_d = reload_val;
            mode_d    = ctrl_if.mode;
            dir_d     = dir_in;
          end
        end
        CR_RUN: begin
          if (tick) begin
            if (!terminal) begin
              run_cnt_d = dir_q ? run_cnt_q - 1'b1 : run_cnt_q + 1'b1;
            end else if (mode_q == CR_LOOP) begin
              run_cnt_d = dir_q ? RUN_TOP : '0;
              wrap_d    = 1'b1;
            end else begin
              state_d = CR_STOP;
              done_d  = 1'b1;
            end
          end
        end
        CR_STOP: begin
          if (ctrl_if.start) begin
            state_d   = CR_RUN;
            run_cnt_d = reload_val;
            mode_d    = ctrl_if.mode;
            dir_d     = dir_in;
          end
        end
        default: begin
          state_d   = CR_IDLE;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_if.run_cnt  = run_cnt_q;
    ctrl_if.run_busy = (state_q == CR_RUN);
    ctrl_if.run_stop = (state_q == CR_STOP);
    ctrl_if.run_done = done_q;
    ctrl_if.run_wrap = wrap_q;
  end

endmodule
